// File: rtl/mem_controller_v2.sv
`default_nettype none
// ============================================================================
// Module   : mem_controller_v2
// Purpose  : CPU memory controller. Holds the MAR and MDR and owns a narrow
//            internal RAM of RAM_W-bit cells. A full DATA_W-bit word moves
//            between the MDR and RAM as BEATS little-endian beats. Each beat
//            is preceded by WAIT_CYCLES idle cycles. A single-clock
//            front-panel path writes RAM cells and auto-increments the MAR.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            data_bus_io           - shared tri-state CPU bus
//            set_mar_i / write_m_i - bus -> MAR / bus -> MDR
//            read_m_i              - MDR -> bus (combinational, IDLE only)
//            read_r_i / write_r_i  - start RAM->MDR / MDR->RAM word transfer
//            busy_o / done_o       - transfer in progress / completion pulse
//            address_o             - current MAR
//            current_ram_o         - RAM[MAR], combinational read
//            programming_mode_i, prog_set_mar_i, prog_write_i - front panel
// Revision : 1.0 - initial release
// ============================================================================
module mem_controller_v2 #(
    parameter int DATA_W      = 16,
    parameter int RAM_W       = 8,
    parameter int DEPTH_LOG2  = 15,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    inout  tri logic [DATA_W-1:0] data_bus_io,
    input  logic                 set_mar_i,
    input  logic                 read_m_i,
    input  logic                 write_m_i,
    input  logic                 read_r_i,
    input  logic                 write_r_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_W-1:0]    address_o,
    output logic [RAM_W-1:0]     current_ram_o,
    input  logic                 programming_mode_i,
    input  logic                 prog_set_mar_i,
    input  logic                 prog_write_i
);

    localparam int BEATS  = DATA_W / RAM_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BEAT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // With no wait states the controller goes straight to the next beat.
    localparam state_t NEXT_BEAT_STATE = (WAIT_CYCLES > 0) ? S_WAIT : S_BEAT;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          wait_q, wait_d;
    logic                dir_wr_q, dir_wr_d;

    logic [RAM_W-1:0]      ram_q [2**DEPTH_LOG2];
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [RAM_W-1:0]      ram_wdata;
    logic [DEPTH_LOG2-1:0] beat_addr;
    logic                  bus_drive;

    // Beat address wraps modulo the RAM depth; MAR upper bits are ignored here.
    assign beat_addr = mar_q[DEPTH_LOG2-1:0] + DEPTH_LOG2'(beat_q);

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        dir_wr_d  = dir_wr_q;
        ram_we    = 1'b0;
        ram_waddr = beat_addr;
        ram_wdata = mdr_q[beat_q*RAM_W +: RAM_W];

        case (state_q)
            S_IDLE: begin
                if (programming_mode_i) begin
                    if (prog_set_mar_i) begin
                        mar_d = data_bus_io;
                    end else if (prog_write_i) begin
                        ram_we    = 1'b1;
                        ram_waddr = mar_q[DEPTH_LOG2-1:0];
                        ram_wdata = data_bus_io[RAM_W-1:0];
                        mar_d     = mar_q + DATA_W'(1);
                    end
                end else if (write_m_i) begin
                    mdr_d = data_bus_io;
                end else if (read_r_i || write_r_i) begin
                    dir_wr_d = !read_r_i;
                    beat_d   = '0;
                    wait_d   = WAIT_INIT;
                    state_d  = NEXT_BEAT_STATE;
                end else if (set_mar_i) begin
                    mar_d = data_bus_io;
                end
            end
            S_WAIT: begin
                if (programming_mode_i) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                    // <= rather than == so a zero count can never stall here.
                    if (wait_q <= 4'd1) begin
                        state_d = S_BEAT;
                    end
                end
            end
            S_BEAT: begin
                if (programming_mode_i) begin
                    // Abort: this beat is not performed.
                    state_d = S_IDLE;
                end else begin
                    if (dir_wr_q) begin
                        ram_we = 1'b1;
                    end else begin
                        mdr_d[beat_q*RAM_W +: RAM_W] = ram_q[beat_addr];
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        wait_d  = WAIT_INIT;
                        state_d = NEXT_BEAT_STATE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mar_q    <= '0;
            mdr_q    <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
            dir_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            dir_wr_q <= dir_wr_d;
        end
    end

    // RAM contents survive reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign address_o     = mar_q;
    assign current_ram_o = ram_q[mar_q[DEPTH_LOG2-1:0]];

    assign bus_drive   = !reset && (state_q == S_IDLE) && read_m_i && !programming_mode_i;
    assign data_bus_io = bus_drive ? mdr_q : 'z;

endmodule
`default_nettype wire

// File: tb/tb_mem_controller_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_controller_v2
// Purpose  : Self-checking bench for mem_controller_v2. A transaction-level
//            model tracks MAR/MDR/RAM and elapsed cycles per transfer; a
//            compare process checks the DUT against it every cycle, and
//            directed sequences check hand-computed literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_controller_v2;

    localparam int DATA_W      = 16;
    localparam int RAM_W       = 8;
    localparam int DEPTH_LOG2  = 15;
    localparam int WAIT_CYCLES = 1;
    localparam int BEATS       = DATA_W / RAM_W;
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int TOTAL       = BEATS * (WAIT_CYCLES + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic set_mar = 0, read_m = 0, write_m = 0, read_r = 0, write_r = 0;
    logic pmode = 0, pset = 0, pwr = 0;
    logic [15:0] tb_bus = '0;
    logic        tb_drv = 1'b0;

    tri   [15:0] bus;
    assign bus = tb_drv ? tb_bus : 16'hzzzz;
    // Undriven bus floats high, so a released bus reads as all ones.
    for (genvar b = 0; b < 16; b++) begin : g_pu
        pullup (bus[b]);
    end

    wire        busy, done;
    wire [15:0] address;
    wire [7:0]  cur;

    mem_controller_v2 #(
        .DATA_W(DATA_W), .RAM_W(RAM_W), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .data_bus_io(bus),
        .set_mar_i(set_mar), .read_m_i(read_m), .write_m_i(write_m),
        .read_r_i(read_r), .write_r_i(write_r),
        .busy_o(busy), .done_o(done), .address_o(address), .current_ram_o(cur),
        .programming_mode_i(pmode), .prog_set_mar_i(pset), .prog_write_i(pwr)
    );

    // Latency-only instances with zero and three wait states.
    logic       lat_rd = 1'b0;
    tri  [15:0] bus_w0, bus_w3;
    wire        busy_w0, done_w0, busy_w3, done_w3;
    wire [15:0] addr_w0, addr_w3;
    wire [7:0]  cur_w0, cur_w3;

    mem_controller_v2 #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset), .data_bus_io(bus_w0),
        .set_mar_i(1'b0), .read_m_i(1'b0), .write_m_i(1'b0),
        .read_r_i(lat_rd), .write_r_i(1'b0),
        .busy_o(busy_w0), .done_o(done_w0), .address_o(addr_w0), .current_ram_o(cur_w0),
        .programming_mode_i(1'b0), .prog_set_mar_i(1'b0), .prog_write_i(1'b0)
    );

    mem_controller_v2 #(.WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .reset(reset), .data_bus_io(bus_w3),
        .set_mar_i(1'b0), .read_m_i(1'b0), .write_m_i(1'b0),
        .read_r_i(lat_rd), .write_r_i(1'b0),
        .busy_o(busy_w3), .done_o(done_w3), .address_o(addr_w3), .current_ram_o(cur_w3),
        .programming_mode_i(1'b0), .prog_set_mar_i(1'b0), .prog_write_i(1'b0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: m_t counts edges since the command was
    // accepted; beat k lands on edge (k+1)*(WAIT_CYCLES+1).
    // ------------------------------------------------------------------
    logic [15:0] m_mar = '0, m_mdr = '0;
    bit          m_busy = 0, m_wr = 0;
    int          m_t = 0;
    logic [7:0]  m_ram [int];

    always @(posedge clk) begin
        if (reset) begin
            m_mar  = '0;
            m_mdr  = '0;
            m_busy = 0;
            m_t    = 0;
        end else if (m_busy) begin
            if (pmode) begin
                m_busy = 0;
            end else begin
                m_t++;
                if (m_t > TOTAL) begin
                    m_busy = 0;
                end else if (m_t % (WAIT_CYCLES + 1) == 0) begin
                    int k, a;
                    k = m_t / (WAIT_CYCLES + 1) - 1;
                    a = (int'(m_mar) + k) % DEPTH;
                    if (m_wr) m_ram[a] = m_mdr[k*RAM_W +: RAM_W];
                    else      m_mdr[k*RAM_W +: RAM_W] = m_ram.exists(a) ? m_ram[a] : 8'hxx;
                end
            end
        end else if (pmode) begin
            if (pset) begin
                m_mar = tb_bus;
            end else if (pwr) begin
                m_ram[int'(m_mar) % DEPTH] = tb_bus[7:0];
                m_mar = m_mar + 16'd1;
            end
        end else if (write_m) begin
            m_mdr = tb_bus;
        end else if (read_r || write_r) begin
            m_busy = 1;
            m_t    = 0;
            m_wr   = !read_r;
        end else if (set_mar) begin
            m_mar = tb_bus;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, m_busy);
            chk("done", done, (m_busy && m_t == TOTAL));
            chk("address", address, m_mar);
            if (m_ram.exists(int'(m_mar) % DEPTH))
                chk("current_ram", cur, m_ram[int'(m_mar) % DEPTH]);
            if (!tb_drv)
                chk("bus", bus, (read_m && !m_busy && !pmode) ? m_mdr : 16'hFFFF);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic cpu_set_mar(input logic [15:0] v);
        tb_bus = v; tb_drv = 1; set_mar = 1;
        step();
        set_mar = 0; tb_drv = 0;
    endtask

    task automatic cpu_write_m(input logic [15:0] v);
        tb_bus = v; tb_drv = 1; write_m = 1;
        step();
        write_m = 0; tb_drv = 0;
    endtask

    task automatic start(input bit wr);
        if (wr) write_r = 1; else read_r = 1;
        step();
        write_r = 0; read_r = 0;
    endtask

    task automatic prog_mar(input logic [15:0] v);
        tb_bus = v; tb_drv = 1; pset = 1;
        step();
        pset = 0; tb_drv = 0;
    endtask

    task automatic prog_cell(input logic [7:0] v);
        tb_bus = {8'h00, v}; tb_drv = 1; pwr = 1;
        step();
        pwr = 0; tb_drv = 0;
    endtask

    // Counts samples after the accepting edge until done; 0 means timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 1) chk("busy_first_cycle", busy, 1'b1);
            if (done) begin
                lat = i;
                break;
            end
            step();
        end
        step();
    endtask

    int lat, l0, l3, seen;

    initial begin
        // Reset
        step(3);
        reset = 0;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_address", address, 16'h0000);
        chk("reset_bus_z", bus, 16'hFFFF);
        step();

        // Word write at 0x0010
        cpu_set_mar(16'h0010);
        cpu_write_m(16'hBEEF);
        start(1);
        wait_done(lat);
        chk("write_latency", lat, 5);
        chk("write_idle_after", busy, 1'b0);
        chk("ram_0010", cur, 8'hEF);
        cpu_set_mar(16'h0011);
        chk("ram_0011", cur, 8'hBE);

        // Preload via front panel, then word read
        pmode = 1;
        prog_mar(16'h0020);
        prog_cell(8'h34);
        prog_cell(8'h12);
        pmode = 0;
        cpu_set_mar(16'h0020);
        start(0);
        wait_done(lat);
        chk("read_latency", lat, 5);
        read_m = 1; #1;
        chk("read_bus", bus, 16'h1234);
        read_m = 0; #1;
        chk("read_bus_released", bus, 16'hFFFF);
        step();

        // Address wrap
        cpu_set_mar(16'h7FFF);
        cpu_write_m(16'hA55A);
        start(1);
        wait_done(lat);
        chk("wrap_latency", lat, 5);
        chk("ram_7fff", cur, 8'h5A);
        cpu_set_mar(16'h0000);
        chk("ram_0000_wrap", cur, 8'hA5);

        // Commands ignored while busy
        cpu_set_mar(16'h0010);
        start(0);
        tb_bus = 16'h0999; tb_drv = 1; set_mar = 1; write_m = 1;
        step();
        set_mar = 0; write_m = 0; tb_drv = 0; read_m = 1;
        #1;
        chk("busy_bus_released", bus, 16'hFFFF);
        step();
        read_m = 0;
        wait_done(lat);
        chk("busy_ignore_latency", lat + 2, 5);
        chk("busy_ignore_mar", address, 16'h0010);
        read_m = 1; #1;
        chk("busy_ignore_mdr", bus, 16'hBEEF);
        read_m = 0;
        step();

        // Programming with MAR auto-increment
        pmode = 1;
        prog_mar(16'h0100);
        prog_cell(8'h11);
        prog_cell(8'h22);
        prog_cell(8'h33);
        chk("prog_mar_incr", address, 16'h0103);
        prog_mar(16'h0101);
        chk("prog_ram_0101", cur, 8'h22);
        pmode = 0;
        step();

        // Programming mode aborts a read after its first beat
        cpu_write_m(16'h0000);
        cpu_set_mar(16'h0020);
        start(0);
        step(2);
        pmode = 1;
        step();
        chk("abort_idle", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen = 1;
            step();
        end
        chk("abort_no_done", seen, 0);
        pmode = 0;
        read_m = 1; #1;
        chk("abort_partial_mdr", bus, 16'h0034);
        read_m = 0;
        step();

        // Reset in the middle of a write: first beat stays written
        cpu_set_mar(16'h0200);
        cpu_write_m(16'h7788);
        start(1);
        step(2);
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_mar", address, 16'h0000);
        step();
        cpu_set_mar(16'h0200);
        chk("midreset_ram_0200", cur, 8'h88);

        // Latency with zero and three wait states
        lat_rd = 1;
        step();
        lat_rd = 0;
        l0 = 0; l3 = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) chk("w3_busy_first", busy_w3, 1'b1);
            if (done_w0 && l0 == 0) l0 = i;
            if (done_w3 && l3 == 0) l3 = i;
            step();
        end
        chk("latency_w0", l0, 3);
        chk("latency_w3", l3, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
